wash_sequencer: RTL and testbench

- Run-time controller for the washing machine; the counterpart of the Model settings block.
- Drives the 3-bit `state` bus that Model consumes.
- Consumes Model's `setData` (enabled phases) and `data` (packed times and water level).
- Sequences fill/wash/rinse/spin/done, drives the actuators, and exposes the remaining time of the current phase for display.

---
 rtl/wash_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Washing machine run-time controller: captures raw buttons, sequences
// fill/wash/rinse/spin/done from Model's settings and drives the actuators.
module wash_sequencer #(
    parameter int TICK_DIV   = 4,
    parameter int FILL_UNITS = 2,
    parameter int DONE_UNITS = 3
) (
    input  logic        cp,
    input  logic        rst_n,
    input  logic        powerBtn,
    input  logic        startBtn,
    input  logic        pauseBtn,
    input  logic [2:0]  setData,
    input  logic [25:0] data,
    output logic [2:0]  state,
    output logic [7:0]  remain,
    output logic        paused,
    output logic        valve,
    output logic        drain,
    output logic [1:0]  motor,
    output logic        buzzer
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_STANDBY = 3'd1,
        S_SETTING = 3'd2,
        S_FILL    = 3'd3,
        S_WASH    = 3'd4,
        S_RINSE   = 3'd5,
        S_SPIN    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam int         PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0] DONE_LOAD = 8'(DONE_UNITS);

    function automatic logic is_run(input state_t st);
        is_run = (st >= S_FILL);
    endfunction

    function automatic logic is_active(input state_t st);
        is_active = (st >= S_FILL) && (st <= S_SPIN);
    endfunction

    // Next phase after the current one expires, skipping disabled phases: {state, remain load}
    function automatic logic [10:0] next_phase(input state_t st, input logic [2:0] en,
                                               input logic [25:0] d);
        case (st)
            S_FILL:  next_phase = en[0] ? {S_WASH, d[7:0]} : {S_RINSE, d[15:8]};
            S_WASH:  next_phase = en[1] ? {S_RINSE, d[15:8]} :
                                  (en[2] ? {S_SPIN, d[23:16]} : {S_DONE, DONE_LOAD});
            S_RINSE: next_phase = en[2] ? {S_SPIN, d[23:16]} : {S_DONE, DONE_LOAD};
            S_SPIN:  next_phase = {S_DONE, DONE_LOAD};
            default: next_phase = {S_STANDBY, 8'd0};
        endcase
    endfunction

    // Actuator image {valve, drain, motor[1:0], buzzer}; pause kills water and motion
    function automatic logic [4:0] act_of(input state_t st, input logic pz);
        case (st)
            S_FILL:  act_of = {~pz, 1'b0, 2'b00, 1'b0};
            S_WASH:  act_of = {1'b0, 1'b0, (pz ? 2'b00 : 2'b01), 1'b0};
            S_RINSE: act_of = {1'b0, ~pz, (pz ? 2'b00 : 2'b01), 1'b0};
            S_SPIN:  act_of = {1'b0, ~pz, (pz ? 2'b00 : 2'b10), 1'b0};
            S_DONE:  act_of = 5'b00001;
            default: act_of = 5'b00000;
        endcase
    endfunction

    logic [2:0] btn_s;
    logic [2:0] evt_s;

    assign btn_s = {pauseBtn, startBtn, powerBtn};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic stretch_r;
        logic sync1_r;
        logic sync2_r;
        logic sync3_r;

        // Catch presses shorter than a clock period; release once the synchronizer has it
        always_ff @(posedge cp or negedge rst_n or posedge btn_s[i]) begin
            if (!rst_n)
                stretch_r <= 1'b0;
            else if (btn_s[i])
                stretch_r <= 1'b1;
            else if (sync2_r)
                stretch_r <= 1'b0;
        end

        // Two-flop synchronizer plus delayed copy for rising-edge detection
        always_ff @(posedge cp or negedge rst_n) begin
            if (!rst_n) begin
                sync1_r <= 1'b0;
                sync2_r <= 1'b0;
                sync3_r <= 1'b0;
            end else begin
                sync1_r <= stretch_r;
                sync2_r <= sync1_r;
                sync3_r <= sync2_r;
            end
        end

        assign evt_s[i] = sync2_r & ~sync3_r;
    end

    state_t          state_r;
    state_t          state_n_s;
    logic [7:0]      remain_r;
    logic [7:0]      remain_n_s;
    logic            paused_r;
    logic            paused_n_s;
    logic [2:0]      en_r;
    logic [2:0]      en_n_s;
    logic            entry_s;
    logic [PW-1:0]   cnt_r;
    logic            run_s;
    logic            tick_s;
    logic [10:0]     np_s;
    logic [7:0]      fill_load_s;

    assign run_s       = is_run(state_r);
    assign tick_s      = run_s && !paused_r && (cnt_r == PW'(TICK_DIV - 1));
    assign np_s        = next_phase(state_r, en_r, data);
    assign fill_load_s = 8'(({6'd0, data[25:24]} + 8'd1) * FILL_UNITS);

    // Next-state, countdown and pause decisions; power overrides everything
    always_comb begin
        state_n_s  = state_r;
        remain_n_s = remain_r;
        paused_n_s = paused_r;
        en_n_s     = en_r;
        entry_s    = 1'b0;
        if (evt_s[0]) begin
            entry_s    = 1'b1;
            remain_n_s = 8'd0;
            paused_n_s = 1'b0;
            state_n_s  = (state_r == S_OFF) ? S_STANDBY : S_OFF;
        end else begin
            case (state_r)
                S_STANDBY: begin
                    if (evt_s[1]) begin
                        state_n_s = S_SETTING;
                        entry_s   = 1'b1;
                    end else begin
                        entry_s = 1'b0;
                    end
                end
                S_SETTING: begin
                    if (evt_s[1] && (setData != 3'd0)) begin
                        en_n_s  = setData;
                        entry_s = 1'b1;
                        if (setData[1:0] != 2'd0) begin
                            state_n_s  = S_FILL;
                            remain_n_s = fill_load_s;
                        end else begin
                            state_n_s  = S_SPIN;
                            remain_n_s = data[23:16];
                        end
                    end else begin
                        entry_s = 1'b0;
                    end
                end
                S_FILL, S_WASH, S_RINSE, S_SPIN, S_DONE: begin
                    if (paused_r) begin
                        entry_s = 1'b0;
                    end else if (remain_r == 8'd0) begin
                        entry_s    = 1'b1;
                        state_n_s  = state_t'(np_s[10:8]);
                        remain_n_s = np_s[7:0];
                    end else if (tick_s) begin
                        remain_n_s = remain_r - 8'd1;
                    end else begin
                        entry_s = 1'b0;
                    end
                end
                default: entry_s = 1'b0;
            endcase
            // A pause that coincides with a move into DONE is dropped, never latched
            paused_n_s = (evt_s[2] && is_active(state_r) && is_active(state_n_s)) ?
                         ~paused_r : paused_r;
        end
    end

    // Prescaler: restarts on every state entry, frozen while paused or idle
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n)
            cnt_r <= '0;
        else if (entry_s)
            cnt_r <= '0;
        else if (run_s && !paused_r)
            cnt_r <= tick_s ? '0 : cnt_r + PW'(1);
    end

    // State and actuator registers, actuators derived from the next state
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_OFF;
            remain_r <= 8'd0;
            paused_r <= 1'b0;
            en_r     <= 3'd0;
            {valve, drain, motor, buzzer} <= 5'b00000;
        end else begin
            state_r  <= state_n_s;
            remain_r <= remain_n_s;
            paused_r <= paused_n_s;
            en_r     <= en_n_s;
            {valve, drain, motor, buzzer} <= act_of(state_n_s, paused_n_s);
        end
    end

    assign state  = state_r;
    assign remain = remain_r;
    assign paused = paused_r;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: button capture, phase sequencing,
// pause freeze, zero-length phases, async reset and event priority.
module tb_wash_sequencer;

    localparam logic [2:0] S_OFF = 3'd0, S_STANDBY = 3'd1, S_SETTING = 3'd2, S_FILL = 3'd3,
                           S_WASH = 3'd4, S_RINSE = 3'd5, S_SPIN = 3'd6, S_DONE = 3'd7;

    logic        cp = 1'b0;
    logic        rst_n = 1'b0;
    logic        powerBtn = 1'b0;
    logic        startBtn = 1'b0;
    logic        pauseBtn = 1'b0;
    logic [2:0]  setData = 3'd0;
    logic [25:0] data = 26'd0;
    logic [2:0]  state;
    logic [7:0]  remain;
    logic        paused;
    logic        valve;
    logic        drain;
    logic [1:0]  motor;
    logic        buzzer;
    logic [4:0]  act;

    int checks = 0;
    int failures = 0;
    int wash_cyc = 0;
    int paused_cyc = 0;

    assign act = {valve, drain, motor, buzzer};

    wash_sequencer dut (
        .cp(cp), .rst_n(rst_n), .powerBtn(powerBtn), .startBtn(startBtn), .pauseBtn(pauseBtn),
        .setData(setData), .data(data), .state(state), .remain(remain), .paused(paused),
        .valve(valve), .drain(drain), .motor(motor), .buzzer(buzzer)
    );

    always #5 cp = ~cp;

    // Cycle counters for the paused-wash duration check
    always @(negedge cp) begin
        if (state == S_WASH) wash_cyc <= wash_cyc + 1;
        if (state == S_WASH && paused) paused_cyc <= paused_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge cp);
    endtask

    // Short pulse wholly between two rising edges
    task automatic press(input int b);
        @(posedge cp);
        #2;
        case (b)
            0: powerBtn = 1'b1;
            1: startBtn = 1'b1;
            default: pauseBtn = 1'b1;
        endcase
        #5;
        powerBtn = 1'b0;
        startBtn = 1'b0;
        pauseBtn = 1'b0;
    endtask

    task automatic press_power_start();
        @(posedge cp);
        #2;
        powerBtn = 1'b1;
        startBtn = 1'b1;
        #5;
        powerBtn = 1'b0;
        startBtn = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while (state !== st && n < budget) begin
            @(negedge cp);
            n++;
        end
        chk(tag, {29'd0, state}, {29'd0, st});
    endtask

    task automatic wait_paused(input string tag, input logic val, input int budget);
        int n = 0;
        while (paused !== val && n < budget) begin
            @(negedge cp);
            n++;
        end
        chk(tag, {31'd0, paused}, {31'd0, val});
    endtask

    // Wait for a phase, check its entry values, then measure how many cycles it lasts
    task automatic run_phase(input string tag, input logic [2:0] st, input logic [7:0] rem,
                             input logic [4:0] a, input int len);
        int n = 0;
        wait_state({tag, "_state"}, st, 120);
        chk({tag, "_remain"}, {24'd0, remain}, {24'd0, rem});
        chk({tag, "_act"}, {27'd0, act}, {27'd0, a});
        while (state === st && n < 500) begin
            n++;
            @(negedge cp);
        end
        chk({tag, "_len"}, n, len);
    endtask

    initial begin
        int w0;
        int p0;
        logic [7:0] r0;

        // 1: reset values and power toggling
        #23;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_remain", {24'd0, remain}, 32'd0);
        chk("rst_paused", {31'd0, paused}, 32'd0);
        chk("rst_act", {27'd0, act}, 32'd0);
        @(negedge cp);
        rst_n = 1'b1;
        idle(2);
        press(0);
        wait_state("pwr_on", S_STANDBY, 4);
        chk("stby_act", {27'd0, act}, 32'd0);
        chk("stby_remain", {24'd0, remain}, 32'd0);
        idle(4);
        press(0);
        wait_state("pwr_off", S_OFF, 4);
        chk("off_act", {27'd0, act}, 32'd0);

        // 2: full cycle, all phases enabled
        idle(4);
        press(0);
        wait_state("t2_stby", S_STANDBY, 6);
        idle(4);
        press(1);
        wait_state("t2_setting", S_SETTING, 6);
        setData = 3'b111;
        data = {2'd1, 8'd2, 8'd1, 8'd3};
        idle(4);
        press(1);
        run_phase("t2_fill", S_FILL, 8'd4, 5'b10000, 17);
        run_phase("t2_wash", S_WASH, 8'd3, 5'b00010, 13);
        run_phase("t2_rinse", S_RINSE, 8'd1, 5'b01010, 5);
        run_phase("t2_spin", S_SPIN, 8'd2, 5'b01100, 9);
        run_phase("t2_done", S_DONE, 8'd3, 5'b00001, 13);
        chk("t2_stby_end", {29'd0, state}, {29'd0, S_STANDBY});
        chk("t2_stby_remain", {24'd0, remain}, 32'd0);
        chk("t2_stby_act", {27'd0, act}, 32'd0);

        // 3: spin only skips fill; empty setData keeps SETTING
        idle(4);
        press(1);
        wait_state("t3_setting", S_SETTING, 6);
        setData = 3'b100;
        data = {2'd0, 8'd5, 8'd0, 8'd0};
        idle(4);
        press(1);
        run_phase("t3_spin", S_SPIN, 8'd5, 5'b01100, 21);
        run_phase("t3_done", S_DONE, 8'd3, 5'b00001, 13);
        idle(4);
        press(1);
        wait_state("t3_setting2", S_SETTING, 6);
        setData = 3'b000;
        idle(4);
        press(1);
        idle(8);
        chk("t3_empty_stays", {29'd0, state}, {29'd0, S_SETTING});

        // 4: pause during a 6-unit wash
        setData = 3'b001;
        data = {2'd0, 8'd0, 8'd0, 8'd6};
        idle(2);
        press(1);
        run_phase("t4_fill", S_FILL, 8'd2, 5'b10000, 9);
        w0 = wash_cyc;
        p0 = paused_cyc;
        chk("t4_wash_state", {29'd0, state}, {29'd0, S_WASH});
        chk("t4_wash_remain", {24'd0, remain}, 32'd6);
        idle(5);
        press(2);
        wait_paused("t4_pause_on", 1'b1, 6);
        chk("t4_paused_act", {27'd0, act}, 32'd0);
        r0 = remain;
        idle(40);
        chk("t4_frozen", {24'd0, remain}, {24'd0, r0});
        chk("t4_still_wash", {29'd0, state}, {29'd0, S_WASH});
        press(2);
        wait_paused("t4_pause_off", 1'b0, 6);
        chk("t4_resume_act", {27'd0, act}, 32'd2);
        wait_state("t4_done", S_DONE, 100);
        chk("t4_wash_len", wash_cyc - w0, 25 + (paused_cyc - p0));
        chk("t4_paused_long", {31'd0, (paused_cyc - p0) >= 40}, 32'd1);
        wait_state("t4_stby", S_STANDBY, 20);

        // 5: zero-length rinse then power-off during spin
        idle(4);
        press(1);
        wait_state("t5_setting", S_SETTING, 6);
        setData = 3'b110;
        data = {2'd0, 8'd2, 8'd0, 8'd0};
        idle(4);
        press(1);
        run_phase("t5_fill", S_FILL, 8'd2, 5'b10000, 9);
        run_phase("t5_rinse0", S_RINSE, 8'd0, 5'b01010, 1);
        chk("t5_spin_state", {29'd0, state}, {29'd0, S_SPIN});
        chk("t5_spin_remain", {24'd0, remain}, 32'd2);
        idle(2);
        press(0);
        wait_state("t5_off", S_OFF, 6);
        chk("t5_off_act", {27'd0, act}, 32'd0);
        chk("t5_off_remain", {24'd0, remain}, 32'd0);
        chk("t5_off_paused", {31'd0, paused}, 32'd0);

        // 6: async reset mid-wash, then power+start together in SETTING
        idle(4);
        press(0);
        wait_state("t6_stby", S_STANDBY, 6);
        idle(4);
        press(1);
        wait_state("t6_setting", S_SETTING, 6);
        setData = 3'b001;
        data = {2'd0, 8'd0, 8'd0, 8'd6};
        idle(4);
        press(1);
        wait_state("t6_wash", S_WASH, 30);
        idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_state", {29'd0, state}, 32'd0);
        chk("t6_async_remain", {24'd0, remain}, 32'd0);
        chk("t6_async_act", {27'd0, act}, 32'd0);
        @(negedge cp);
        rst_n = 1'b1;
        idle(2);
        press(0);
        wait_state("t6_stby2", S_STANDBY, 6);
        idle(4);
        press(1);
        wait_state("t6_setting2", S_SETTING, 6);
        idle(4);
        press_power_start();
        wait_state("t6_prio_off", S_OFF, 6);
        idle(8);
        chk("t6_stays_off", {29'd0, state}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
